// File: rtl/motion_pkg.sv
// Shared types and fixed-point helpers for the sprite motion engine.
// Helpers work on 32-bit signed values, so internal widths must stay <= 32 bits.
package motion_pkg;

  typedef enum logic [3:0] {
    C_RESET,
    C_IDLE,
    C_LEFT,
    C_RIGHT,
    C_DOWN,
    C_UP,
    C_DIE,
    C_BOUNCE_L,
    C_BOUNCE_R,
    C_BOUNCE_T
  } cmd_t;

  function automatic logic signed [31:0] to_fp(input logic signed [31:0] px, input int frac_bits);
    return px <<< frac_bits;
  endfunction

  function automatic logic signed [31:0] to_px(input logic signed [31:0] fp, input int frac_bits);
    return fp >>> frac_bits;
  endfunction

  // Clearing the low bits floors toward -inf, so negative positions map to the tile below.
  function automatic logic signed [31:0] tile_origin(input logic signed [31:0] pos, input int clr_bits);
    logic signed [31:0] mask;
    mask = (32'sd1 <<< clr_bits) - 32'sd1;
    return pos & ~mask;
  endfunction

endpackage

// File: rtl/sprite_motion_engine_if.sv
// Controller-facing bus of the sprite motion engine: frame strobe, command,
// position-load handshake and the motion outputs consumed by the draw block.
interface sprite_motion_engine_if
  import motion_pkg::*;
#(
  parameter int POS_W     = 11,
  parameter int FRAC_BITS = 6
);

  logic                              start_of_frame;
  cmd_t                              cmd;
  logic                              load_valid;
  logic signed [POS_W-1:0]           load_x;
  logic signed [POS_W-1:0]           load_y;
  logic                              load_ready;
  logic signed [POS_W-1:0]           offset_x;
  logic signed [POS_W-1:0]           offset_y;
  logic signed [POS_W+FRAC_BITS-1:0] vel_x;
  logic signed [POS_W+FRAC_BITS-1:0] vel_y;
  logic [3:0]                        edge_hit;
  logic                              moving;

  modport master (
    output start_of_frame, cmd, load_valid, load_x, load_y,
    input  load_ready, offset_x, offset_y, vel_x, vel_y, edge_hit, moving
  );

  modport slave (
    input  start_of_frame, cmd, load_valid, load_x, load_y,
    output load_ready, offset_x, offset_y, vel_x, vel_y, edge_hit, moving
  );

endinterface

// File: rtl/motion_axis.sv
// One axis of sprite motion: position/velocity registers, ramp toward a target,
// speed saturation and tile-bound comparison. Target selection lives in the parent.
module motion_axis
  import motion_pkg::*;
#(
  parameter int W         = 18,
  parameter int FRAC_BITS = 6,
  parameter int TILE_PX   = 64,
  parameter int SPRITE_PX = 16,
  parameter int MARGIN_FP = 10,
  parameter int MAX_SPEED = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic signed [W-1:0] load_pos,
  input  logic                frame_en,
  input  logic                recenter,
  input  logic                freeze,
  input  logic                immediate,
  input  logic signed [W-1:0] target,
  input  logic signed [W-1:0] step,
  output logic signed [W-1:0] pos,
  output logic signed [W-1:0] vel,
  output logic                below_lo,
  output logic                above_hi
);

  localparam int TILE_BITS = $clog2(TILE_PX) + FRAC_BITS;
  localparam logic signed [W-1:0] CENTER_OFF = W'(((TILE_PX - SPRITE_PX) / 2) << FRAC_BITS);
  localparam logic signed [W-1:0] LO_OFF     = W'(MARGIN_FP);
  localparam logic signed [W-1:0] HI_OFF     = W'(((TILE_PX - SPRITE_PX) << FRAC_BITS) - MARGIN_FP);
  localparam logic signed [W-1:0] VMAX       = W'(MAX_SPEED);

  logic signed [W-1:0] pos_q, pos_d;
  logic signed [W-1:0] vel_q, vel_d;
  logic signed [W-1:0] tile;
  logic signed [W-1:0] ramp;
  logic signed [W-1:0] vel_next;
  logic signed [W-1:0] vel_up;
  logic signed [W-1:0] vel_dn;

  assign tile     = W'(tile_origin(32'(pos_q), TILE_BITS));
  assign below_lo = pos_q < (tile + LO_OFF);
  assign above_hi = pos_q > (tile + HI_OFF);
  assign vel_up   = vel_q + step;
  assign vel_dn   = vel_q - step;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    ramp     = target;
    vel_next = ramp;
    pos_d    = pos_q;
    vel_d    = vel_q;

    if (vel_q < target) begin
      ramp = (vel_up > target) ? target : vel_up;
    end else if (vel_q > target) begin
      ramp = (vel_dn < target) ? target : vel_dn;
    end

    vel_next = immediate ? target : ramp;
    if (vel_next > VMAX) begin
      vel_next = VMAX;
    end else if (vel_next < -VMAX) begin
      vel_next = -VMAX;
    end

    // A load always beats a coincident frame update.
    if (load_en) begin
      pos_d = load_pos;
      vel_d = '0;
    end else if (frame_en) begin
      if (recenter) begin
        pos_d = tile + CENTER_OFF;
        vel_d = '0;
      end else if (freeze) begin
        vel_d = '0;
      end else begin
        pos_d = pos_q + vel_q;
        vel_d = vel_next;
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= CENTER_OFF;
      vel_q <= '0;
    end else begin
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  end

  assign pos = pos_q;
  assign vel = vel_q;

endmodule

// File: rtl/sprite_motion_engine.sv
// Per-sprite motion engine top: per-axis target selection, load handshake, edge reporting.
// Optional macro SPRITE_MOTION_GRAVITY_EN replaces Y oscillation with a gravity fall/bounce.
module sprite_motion_engine
  import motion_pkg::*;
#(
  parameter int FRAC_BITS = 6,
  parameter int TILE_PX   = 64,
  parameter int SPRITE_PX = 16,
  parameter int POS_W     = 11,
  parameter int ACCEL     = 4,
  parameter int MAX_SPEED = 20,
  parameter int MARGIN_FP = 10
) (
  input logic clk,
  input logic reset,
  sprite_motion_engine_if.slave bus
);

  localparam int W     = POS_W + FRAC_BITS + 1;
  localparam int VEL_W = POS_W + FRAC_BITS;
  localparam logic signed [W-1:0] VMAX      = W'(MAX_SPEED);
  localparam logic signed [W-1:0] ZERO      = '0;
  localparam logic signed [W-1:0] STEP_RAMP = W'(ACCEL);
`ifdef SPRITE_MOTION_GRAVITY_EN
  localparam logic signed [W-1:0] STEP_FALL = W'(ACCEL / 2);
`endif

  logic                load_ready;
  logic                load_fire;
  logic                frame_upd;
  logic                recenter;
  logic                freeze;
  logic signed [W-1:0] load_pos_x, load_pos_y;
  logic signed [W-1:0] pos_x, pos_y, vel_x, vel_y;
  logic                x_below_lo, x_above_hi, y_below_lo, y_above_hi;
  logic signed [W-1:0] tgt_x, tgt_y, step_y;
  logic                imm_x, imm_y;
  logic                hit_l, hit_r, hit_t, hit_b;
  logic [3:0]          edge_hit_q, edge_hit_d;

  assign load_ready = (bus.cmd != C_DIE);
  assign load_fire  = bus.load_valid && load_ready;
  assign frame_upd  = bus.start_of_frame && !load_fire;
  assign recenter   = (bus.cmd == C_RESET);
  assign freeze     = (bus.cmd == C_DIE);
  assign load_pos_x = W'(to_fp(32'(bus.load_x), FRAC_BITS));
  assign load_pos_y = W'(to_fp(32'(bus.load_y), FRAC_BITS));

  // X target: ramped except for the bounce commands and the velocity kills.
  always_comb begin
    tgt_x = ZERO;
    imm_x = 1'b0;
    hit_l = 1'b0;
    hit_r = 1'b0;
    case (bus.cmd)
      C_RESET, C_DIE: imm_x = 1'b1;
      C_LEFT:         tgt_x = -VMAX;
      C_RIGHT:        tgt_x = VMAX;
      C_BOUNCE_L: begin
        imm_x = 1'b1;
        // NOTE: compare against a signed zero; an unsized '0 would turn this into an unsigned compare.
        if (x_below_lo && vel_x <= ZERO) begin
          tgt_x = VMAX;
          hit_l = 1'b1;
        end else begin
          tgt_x = -VMAX;
        end
      end
      C_BOUNCE_R: begin
        imm_x = 1'b1;
        if (x_above_hi && vel_x >= ZERO) begin
          tgt_x = -VMAX;
          hit_r = 1'b1;
        end else begin
          tgt_x = VMAX;
        end
      end
      default: tgt_x = ZERO;
    endcase
  end

  always_comb begin
    tgt_y  = ZERO;
    imm_y  = 1'b0;
    step_y = STEP_RAMP;
    hit_t  = 1'b0;
    hit_b  = 1'b0;
    case (bus.cmd)
      C_RESET, C_DIE: imm_y = 1'b1;
      C_DOWN:         tgt_y = VMAX;
      C_UP:           tgt_y = -VMAX;
      C_BOUNCE_T: begin
        imm_y = 1'b1;
        if (y_below_lo && vel_y <= ZERO) begin
          tgt_y = VMAX;
          hit_t = 1'b1;
        end else begin
          tgt_y = -VMAX;
        end
      end
      default: begin
`ifdef SPRITE_MOTION_GRAVITY_EN
        step_y = STEP_FALL;
        tgt_y  = VMAX;
        if (y_above_hi && vel_y >= ZERO) begin
          imm_y = 1'b1;
          tgt_y = -VMAX;
          hit_b = 1'b1;
        end
`else
        // Oscillation keeps the current direction until a tile bound turns it.
        tgt_y = (vel_y < ZERO) ? -VMAX : VMAX;
        if (y_above_hi && vel_y >= ZERO) begin
          tgt_y = -VMAX;
          hit_b = 1'b1;
        end
        if (y_below_lo && vel_y <= ZERO) begin
          tgt_y = VMAX;
          hit_t = 1'b1;
        end
`endif
      end
    endcase
  end

  assign edge_hit_d = frame_upd ? {hit_t, hit_b, hit_r, hit_l} : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_hit_q <= 4'b0000;
    end else begin
      edge_hit_q <= edge_hit_d;
    end
  end

  motion_axis #(
    .W(W), .FRAC_BITS(FRAC_BITS), .TILE_PX(TILE_PX), .SPRITE_PX(SPRITE_PX),
    .MARGIN_FP(MARGIN_FP), .MAX_SPEED(MAX_SPEED)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_fire),
    .load_pos  (load_pos_x),
    .frame_en  (bus.start_of_frame),
    .recenter  (recenter),
    .freeze    (freeze),
    .immediate (imm_x),
    .target    (tgt_x),
    .step      (STEP_RAMP),
    .pos       (pos_x),
    .vel       (vel_x),
    .below_lo  (x_below_lo),
    .above_hi  (x_above_hi)
  );

  motion_axis #(
    .W(W), .FRAC_BITS(FRAC_BITS), .TILE_PX(TILE_PX), .SPRITE_PX(SPRITE_PX),
    .MARGIN_FP(MARGIN_FP), .MAX_SPEED(MAX_SPEED)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_fire),
    .load_pos  (load_pos_y),
    .frame_en  (bus.start_of_frame),
    .recenter  (recenter),
    .freeze    (freeze),
    .immediate (imm_y),
    .target    (tgt_y),
    .step      (step_y),
    .pos       (pos_y),
    .vel       (vel_y),
    .below_lo  (y_below_lo),
    .above_hi  (y_above_hi)
  );

  assign bus.load_ready = load_ready;
  assign bus.offset_x   = POS_W'(to_px(32'(pos_x), FRAC_BITS));
  assign bus.offset_y   = POS_W'(to_px(32'(pos_y), FRAC_BITS));
  assign bus.vel_x      = VEL_W'(vel_x);
  assign bus.vel_y      = VEL_W'(vel_y);
  assign bus.edge_hit   = edge_hit_q;
  assign bus.moving     = (vel_x != ZERO) || (vel_y != ZERO);

endmodule

// File: doc/sprite_motion_engine.md
Name: sprite_motion_engine

Overview:
- Parametrised per-sprite motion engine: signed fixed-point X/Y position, velocity with acceleration ramp and saturation, tile-bounded idle oscillation and bounce.
- Integrates once per frame, on the start_of_frame pulse.
- Sits between a sprite controller FSM (drives cmd) and the sprite draw block (consumes pixel offsets).
- Adds over the previous generation: configurable fixed-point, tile and sprite geometry; acceleration ramp; explicit position-load handshake; edge-hit reporting.

Parameters:
- FRAC_BITS, 6: fractional bits of position/velocity; scale = 2^FRAC_BITS.
- TILE_PX, 64: tile edge in pixels; power of 2.
- SPRITE_PX, 16: sprite edge in pixels; must be < TILE_PX - 2*MARGIN_PX.
- POS_W, 11: integer bits of pixel offset outputs (signed).
- ACCEL, 4: velocity step per frame, fixed-point units.
- MAX_SPEED, 20: velocity magnitude limit, fixed-point units.
- MARGIN_FP, 10: turn-around margin inside tile edges, fixed-point units.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start_of_frame, in, 1: one-cycle pulse per frame.
- cmd, in, 4: motion_pkg::cmd_t {C_RESET, C_IDLE, C_LEFT, C_RIGHT, C_DOWN, C_UP, C_DIE, C_BOUNCE_L, C_BOUNCE_R, C_BOUNCE_T}.
- load_valid, in, 1: request to load the position.
- load_x, in, POS_W: signed pixel X to load.
- load_y, in, POS_W: signed pixel Y to load.
- load_ready, out, 1: load accepted when load_valid && load_ready.
- offset_x, out, POS_W: pixel top-left X = pos_x >>> FRAC_BITS (arithmetic shift).
- offset_y, out, POS_W: pixel top-left Y.
- vel_x, out, POS_W+FRAC_BITS: signed current X velocity.
- vel_y, out, POS_W+FRAC_BITS: signed current Y velocity.
- edge_hit, out, 4: {top, bottom, right, left}; one-cycle pulses.
- moving, out, 1: high when vel_x != 0 or vel_y != 0.

Behaviour:
- Reset values:
  - pos_x = pos_y = (TILE_PX-SPRITE_PX)/2 << FRAC_BITS, so offsets are 24,24 at default parameters.
  - vel_x = vel_y = 0; edge_hit = 0; moving = 0; load_ready = 1.
- Tile origin: tile_x = pos_x with the low log2(TILE_PX)+FRAC_BITS bits cleared; tile_y likewise. Lo = tile + MARGIN_FP. Hi = tile + (TILE_PX-SPRITE_PX)<<FRAC_BITS - MARGIN_FP.
- Updates happen only in a cycle with start_of_frame=1. Position integrates with the old velocity: pos <= pos + vel. Velocity is updated in the same cycle, so it takes effect on the next frame.
- Ramp: a target velocity T is chosen per axis; vel moves toward T by ACCEL per frame, never overshooting T, and |vel| <= MAX_SPEED always.
- X target per cmd:
  - C_RESET, C_IDLE, C_DOWN, C_UP, C_BOUNCE_T, C_DIE: 0.
  - C_LEFT: -MAX_SPEED. C_RIGHT: +MAX_SPEED.
  - C_BOUNCE_L: +MAX_SPEED if pos_x < Lo and vel_x <= 0, else -MAX_SPEED; the selected target is loaded directly, with no ramp.
  - C_BOUNCE_R: mirror of C_BOUNCE_L using Hi.
- Y target per cmd:
  - C_RESET, C_DIE: 0, applied immediately with no ramp.
  - C_DOWN: +MAX_SPEED. C_UP: -MAX_SPEED.
  - C_IDLE, C_LEFT, C_RIGHT, C_BOUNCE_L, C_BOUNCE_R: oscillation. If vel_y == 0, target = +MAX_SPEED. If pos_y > Hi and vel_y >= 0, target = -MAX_SPEED. If pos_y < Lo and vel_y <= 0, target = +MAX_SPEED. The last matching rule wins.
  - C_BOUNCE_T: immediate +MAX_SPEED if pos_y < tile_y + MARGIN_FP and vel_y <= 0, else -MAX_SPEED.
- edge_hit: asserted for the one cycle after a frame update in which the corresponding Lo/Hi comparison triggered a sign reversal.
- C_DIE: velocities forced to 0; position frozen; load_ready = 0.
- C_RESET: velocities forced to 0; position returns to the tile centre on the next frame.
- Load:
  - On handshake, pos <= {load, FRAC_BITS'b0} and both velocities are cleared.
  - If a load and start_of_frame occur in the same cycle, the load wins and integration is skipped that frame.
  - load_ready is combinational: !(cmd == C_DIE).
- Arithmetic: internal pos/vel are signed, width POS_W+FRAC_BITS+1. Position wrap-around is two's complement and is not clamped.
- Reset asserted mid-frame restores all reset values asynchronously.

Optional Feature:
- SPRITE_MOTION_GRAVITY_EN defined: in the Y oscillation cmds, the target becomes +MAX_SPEED (fall) with ramp ACCEL/2 per frame. Reaching Hi forces immediate vel_y = -MAX_SPEED and pulses edge_hit[bottom]. C_UP/C_DOWN are unchanged.
- Undefined: oscillation as specified above.

Decomposition:
- motion_pkg holds: cmd_t enum; fixed-point helper functions to_fp() and to_px(); the tile_origin() function.
- Natural sub-module: motion_axis. It holds one axis's pos/vel registers, ramp, saturation and bounds compare, and is instanced for X and Y with the per-axis target select in the parent.

Test Plan:
- Reset release, 3 frames of C_IDLE -> offsets 24,24 at reset; vel_y = 4, 8, 12 after frames 1-3; vel_x = 0.
- C_RIGHT held 10 frames -> vel_x 4, 8, 12, 16, 20, 20, ...; offset_x increases monotonically.
- C_BOUNCE_L with pos_x forced near the left edge (load_x = 0) -> vel_x = +20 immediately; edge_hit[0] pulses one cycle.
- load_valid with load_x = 100, load_y = -5 coincident with start_of_frame -> offsets 100,-5; vel = 0; no integration that frame.
- C_DIE -> vel 0, offsets frozen, load_ready = 0. Reset asserted mid-frame -> immediate return to 24,24.
- Macro defined, C_IDLE -> vel_y ramps by 2 per frame to 20; hitting Hi gives vel_y = -20 and edge_hit[bottom] pulses.
